// File: rtl/imu_bias_cal.sv
// Gyro bias calibration and correction: discards settling samples, averages
// 2^LOG2_N stationary samples per axis, then streams bias-corrected gyro data.
module imu_bias_cal #(
   parameter int LOG2_N       = 6,
   parameter int DISCARD      = 4,
   parameter int MOTION_LIMIT = 2000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic signed [15:0] accel_x_in,
   input  logic signed [15:0] accel_y_in,
   input  logic signed [15:0] accel_z_in,
   input  logic signed [15:0] gyro_x_in,
   input  logic signed [15:0] gyro_y_in,
   input  logic signed [15:0] gyro_z_in,
   input  logic               recal,
   output logic signed [15:0] accel_x,
   output logic signed [15:0] accel_y,
   output logic signed [15:0] accel_z,
   output logic signed [15:0] gyro_x,
   output logic signed [15:0] gyro_y,
   output logic signed [15:0] gyro_z,
   output logic               out_valid,
   output logic               cal_done,
   output logic signed [15:0] bias_x,
   output logic signed [15:0] bias_y,
   output logic signed [15:0] bias_z,
   output logic [7:0]         cal_restarts,
   output logic [1:0]         cal_state
);

   // Handshake: in_valid is a one-cycle strobe with no backpressure; every
   // strobe is consumed on the edge that samples it. out_valid is a one-cycle
   // strobe qualifying the six data outputs, which hold when it is low.

   localparam int AW = 16 + LOG2_N;
   localparam int CW = LOG2_N + 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'((1 << LOG2_N) - 1);
   localparam logic [7:0]    DISC_LAST = 8'((DISCARD > 0) ? DISCARD - 1 : 0);
   localparam logic [16:0]   LIMIT     = 17'(MOTION_LIMIT);

   typedef enum logic [1:0] {
      S_DISCARD = 2'd0,
      S_ACCUM   = 2'd1,
      S_RUN     = 2'd2
   } state_t;

   localparam state_t INIT_STATE = (DISCARD == 0) ? S_ACCUM : S_DISCARD;

   state_t                state;
   logic [7:0]            disc_cnt;
   logic [CW-1:0]         cnt;
   logic signed [AW-1:0]  acc_x, acc_y, acc_z;
   logic signed [AW-1:0]  sum_x, sum_y, sum_z;
   logic                  motion;

   // 17-bit magnitude so that -32768 maps to +32768 rather than wrapping.
   function automatic logic [16:0] abs17(input logic signed [15:0] v);
      logic signed [16:0] e;
      e = 17'(v);
      return (e < 0) ? 17'(-e) : 17'(e);
   endfunction

   function automatic logic signed [15:0] sat_sub(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
      logic signed [16:0] d;
      d = 17'(a) - 17'(b);
      if (d[16] != d[15]) return d[16] ? 16'sh8000 : 16'sh7fff;
      return d[15:0];
   endfunction

   always_comb begin
      sum_x  = acc_x + AW'(gyro_x_in);
      sum_y  = acc_y + AW'(gyro_y_in);
      sum_z  = acc_z + AW'(gyro_z_in);
      motion = (abs17(gyro_x_in) > LIMIT) || (abs17(gyro_y_in) > LIMIT) ||
               (abs17(gyro_z_in) > LIMIT);
   end

   assign cal_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= INIT_STATE;
         disc_cnt     <= '0;
         cnt          <= '0;
         acc_x        <= '0;
         acc_y        <= '0;
         acc_z        <= '0;
         accel_x      <= '0;
         accel_y      <= '0;
         accel_z      <= '0;
         gyro_x       <= '0;
         gyro_y       <= '0;
         gyro_z       <= '0;
         out_valid    <= 1'b0;
         cal_done     <= 1'b0;
         bias_x       <= '0;
         bias_y       <= '0;
         bias_z       <= '0;
         cal_restarts <= '0;
      end else begin
         out_valid <= 1'b0;
         if (recal) begin
            // Bias registers intentionally keep the previous estimate.
            state        <= INIT_STATE;
            disc_cnt     <= '0;
            cnt          <= '0;
            acc_x        <= '0;
            acc_y        <= '0;
            acc_z        <= '0;
            cal_restarts <= '0;
            cal_done     <= 1'b0;
         end else if (in_valid) begin
            case (state)
               S_DISCARD: begin
                  if (disc_cnt == DISC_LAST) begin
                     state    <= S_ACCUM;
                     disc_cnt <= '0;
                     cnt      <= '0;
                     acc_x    <= '0;
                     acc_y    <= '0;
                     acc_z    <= '0;
                  end else begin
                     disc_cnt <= disc_cnt + 8'd1;
                  end
               end
               S_ACCUM: begin
                  if (motion) begin
                     cnt   <= '0;
                     acc_x <= '0;
                     acc_y <= '0;
                     acc_z <= '0;
                     if (cal_restarts != 8'hff) cal_restarts <= cal_restarts + 8'd1;
                  end else if (cnt == LAST_CNT) begin
                     // Arithmetic shift floors toward -inf.
                     bias_x   <= 16'(sum_x >>> LOG2_N);
                     bias_y   <= 16'(sum_y >>> LOG2_N);
                     bias_z   <= 16'(sum_z >>> LOG2_N);
                     cal_done <= 1'b1;
                     state    <= S_RUN;
                     cnt      <= '0;
                     acc_x    <= '0;
                     acc_y    <= '0;
                     acc_z    <= '0;
                  end else begin
                     acc_x <= sum_x;
                     acc_y <= sum_y;
                     acc_z <= sum_z;
                     cnt   <= cnt + CW'(1);
                  end
               end
               S_RUN: begin
                  accel_x   <= accel_x_in;
                  accel_y   <= accel_y_in;
                  accel_z   <= accel_z_in;
                  gyro_x    <= sat_sub(gyro_x_in, bias_x);
                  gyro_y    <= sat_sub(gyro_y_in, bias_y);
                  gyro_z    <= sat_sub(gyro_z_in, bias_z);
                  out_valid <= 1'b1;
               end
               default: state <= INIT_STATE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imu_bias_cal.sv
// Directed bench for imu_bias_cal: an arithmetic reference model checked every
// cycle, plus literal expectations that pin the model at key points.
module tb_imu_bias_cal;

   localparam int LOG2_N = 2;
   localparam int NS     = 1 << LOG2_N;
   localparam int DISC   = 1;
   localparam int LIMIT  = 2000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic recal = 1'b0;
   logic signed [15:0] ax_in = '0, ay_in = '0, az_in = '0;
   logic signed [15:0] gx_in = '0, gy_in = '0, gz_in = '0;
   logic signed [15:0] accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z;
   logic signed [15:0] bias_x, bias_y, bias_z;
   logic out_valid, cal_done;
   logic [7:0] cal_restarts;
   logic [1:0] cal_state;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   imu_bias_cal #(.LOG2_N(LOG2_N), .DISCARD(DISC), .MOTION_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .accel_x_in(ax_in), .accel_y_in(ay_in), .accel_z_in(az_in),
      .gyro_x_in(gx_in), .gyro_y_in(gy_in), .gyro_z_in(gz_in),
      .recal(recal),
      .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
      .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
      .out_valid(out_valid), .cal_done(cal_done),
      .bias_x(bias_x), .bias_y(bias_y), .bias_z(bias_z),
      .cal_restarts(cal_restarts), .cal_state(cal_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // reference model: phase 0 = discarding, 1 = averaging, 2 = running
   int m_phase, m_seen, m_cnt;
   int m_sum[3];
   int e_acc[3], e_gyr[3], e_bias[3];
   int e_ov, e_done, e_rst;

   function automatic int floor_div(input int s, input int n);
      if (s >= 0) return s / n;
      return -((-s + n - 1) / n);
   endfunction

   function automatic int clamp16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_reset();
      m_phase = (DISC == 0) ? 1 : 0;
      m_seen = 0; m_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         m_sum[i] = 0; e_acc[i] = 0; e_gyr[i] = 0; e_bias[i] = 0;
      end
      e_ov = 0; e_done = 0; e_rst = 0;
   endtask

   task automatic model_step(input bit v, input bit rc, input int a[3], input int g[3]);
      e_ov = 0;
      if (rc) begin
         m_phase = (DISC == 0) ? 1 : 0;
         m_seen = 0; m_cnt = 0;
         for (int i = 0; i < 3; i++) m_sum[i] = 0;
         e_rst = 0; e_done = 0;
      end else if (v) begin
         if (m_phase == 0) begin
            m_seen++;
            if (m_seen == DISC) begin
               m_phase = 1; m_cnt = 0;
               for (int i = 0; i < 3; i++) m_sum[i] = 0;
            end
         end else if (m_phase == 1) begin
            if (iabs(g[0]) > LIMIT || iabs(g[1]) > LIMIT || iabs(g[2]) > LIMIT) begin
               m_cnt = 0;
               for (int i = 0; i < 3; i++) m_sum[i] = 0;
               if (e_rst < 255) e_rst++;
            end else begin
               for (int i = 0; i < 3; i++) m_sum[i] += g[i];
               m_cnt++;
               if (m_cnt == NS) begin
                  for (int i = 0; i < 3; i++) e_bias[i] = floor_div(m_sum[i], NS);
                  e_done = 1; m_phase = 2;
               end
            end
         end else begin
            for (int i = 0; i < 3; i++) begin
               e_acc[i] = a[i];
               e_gyr[i] = clamp16(g[i] - e_bias[i]);
            end
            e_ov = 1;
         end
      end
   endtask

   // scoreboard helpers
   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (cmp_en) begin
         chk("out_valid", int'(out_valid), e_ov);
         chk("cal_done", int'(cal_done), e_done);
         chk("cal_restarts", int'(cal_restarts), e_rst);
         chk("bias_x", int'(bias_x), e_bias[0]);
         chk("bias_y", int'(bias_y), e_bias[1]);
         chk("bias_z", int'(bias_z), e_bias[2]);
         chk("accel_x", int'(accel_x), e_acc[0]);
         chk("accel_y", int'(accel_y), e_acc[1]);
         chk("accel_z", int'(accel_z), e_acc[2]);
         chk("gyro_x", int'(gyro_x), e_gyr[0]);
         chk("gyro_y", int'(gyro_y), e_gyr[1]);
         chk("gyro_z", int'(gyro_z), e_gyr[2]);
      end
   end

   // driver tasks: inputs change 2 time units after the active edge
   task automatic drive(input bit v, input bit rc, input int a0, input int a1, input int a2,
                        input int g0, input int g1, input int g2);
      int a[3];
      int g[3];
      @(posedge clk); #2;
      in_valid = v; recal = rc;
      ax_in = 16'(a0); ay_in = 16'(a1); az_in = 16'(a2);
      gx_in = 16'(g0); gy_in = 16'(g1); gz_in = 16'(g2);
      a[0] = int'(ax_in); a[1] = int'(ay_in); a[2] = int'(az_in);
      g[0] = int'(gx_in); g[1] = int'(gy_in); g[2] = int'(gz_in);
      model_step(v, rc, a, g);
   endtask

   task automatic gyro(input int g0, input int g1, input int g2);
      drive(1'b1, 1'b0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 65535)), g0, g1, g2);
   endtask

   // idle cycle with random data on the bus to show it is ignored
   task automatic idle();
      drive(1'b0, 1'b0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
   endtask

   task automatic async_reset();
      @(posedge clk); #2;
      rst_n = 1'b0; in_valid = 1'b0; recal = 1'b0;
      model_reset();
      #1;
      chk("rst_bias_x", int'(bias_x), 0);
      chk("rst_gyro_x", int'(gyro_x), 0);
      chk("rst_cal_done", int'(cal_done), 0);
      chk("rst_restarts", int'(cal_restarts), 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // basic calibration with idle gaps; first sample is discarded
      gyro(99, 0, 0);   idle();
      gyro(1, -1, 0);
      gyro(2, -2, 0);   idle(); idle();
      gyro(2, -2, 0);
      gyro(2, -2, 0);
      idle();
      chk("lit_bias_x", int'(bias_x), 1);
      chk("lit_bias_y", int'(bias_y), -2);
      chk("lit_bias_z", int'(bias_z), 0);
      chk("lit_cal_done", int'(cal_done), 1);

      // first corrected sample
      drive(1'b1, 1'b0, 100, -200, 300, 5, 10, 0);
      idle();
      chk("lit_gyro_y", int'(gyro_y), 12);
      chk("lit_gyro_x", int'(gyro_x), 4);
      chk("lit_ov", int'(out_valid), 1);
      chk("lit_accel_y", int'(accel_y), -200);

      // saturation both ways, accel bit-exact extremes
      drive(1'b1, 1'b0, 32767, -32768, 16'h1234, -32768, 32767, 0);
      idle();
      chk("lit_sat_lo", int'(gyro_x), -32768);
      chk("lit_sat_hi", int'(gyro_y), 32767);
      chk("lit_accel_x", int'(accel_x), 32767);
      chk("lit_accel_y2", int'(accel_y), -32768);

      // back-to-back random stream
      for (int i = 0; i < 8; i++)
         gyro(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)));
      idle();

      // recal coincident with a strobe
      drive(1'b1, 1'b1, 1, 2, 3, 4, 5, 6);
      idle();
      chk("lit_recal_ov", int'(out_valid), 0);
      chk("lit_recal_done", int'(cal_done), 0);
      chk("lit_recal_bias", int'(bias_x), 1);
      chk("lit_recal_rst", int'(cal_restarts), 0);

      // discard, then motion restarts in the 3rd slot and on -32768
      gyro(500, 500, 500);
      gyro(0, 0, 10);
      gyro(0, 0, 20);
      gyro(0, 0, 2001);
      idle();
      chk("lit_restart1", int'(cal_restarts), 1);
      gyro(0, -32768, 0);
      gyro(2000, 0, 4);
      gyro(0, 0, 8);
      gyro(0, 0, -4);
      gyro(0, -3, -1);
      idle();
      chk("lit_restart2", int'(cal_restarts), 2);
      chk("lit_mean_x", int'(bias_x), 500);
      chk("lit_mean_y", int'(bias_y), -1);
      chk("lit_mean_z", int'(bias_z), 1);
      gyro(600, 0, 1);
      idle();
      chk("lit_post_x", int'(gyro_x), 100);

      // async reset mid-accumulation restores full discard
      drive(1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
      gyro(3, 3, 3);
      gyro(40, 40, 40);
      gyro(50, 50, 50);
      async_reset();
      gyro(7, 0, 0);
      gyro(1, -5, 0);
      gyro(1, -5, 0);
      gyro(1, -5, 0);
      gyro(1, -5, 0);
      idle();
      chk("lit_rr_bias_x", int'(bias_x), 1);
      chk("lit_rr_bias_y", int'(bias_y), -5);
      gyro(-32768, 32767, 123);
      idle(); idle();

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
